// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
//   Phase sequencer for a two-road intersection with a pedestrian crossing
//   over the main road. A prescaler turns clk into one-second ticks, and a
//   per-phase seconds countdown selects when the FSM moves to the next phase.
//   Lamps are decoded straight from the state register.
//
//   Optional feature macro: TLC_PED_SHORTEN_EN
//     When it is defined, a pending pedestrian request cuts main green down
//     to MIN_GREEN_SEC seconds.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   ped_req      debounced pedestrian button level (1 = pressed)
//   night_mode   debounced night switch level (1 = night)
//   main_light   main-road lamps {R,Y,G}
//   side_light   side-road lamps {R,Y,G}
//   ped_walk     walk lamp
//   sec_left     seconds remaining in the current phase
//   state_o      current state encoding
//   ped_pending  pedestrian request latched and not yet served
module traffic_light_ctrl #(
    parameter int CLK_TICKS     = 50000000,
    parameter int GREEN_SEC     = 30,
    parameter int YELLOW_SEC    = 3,
    parameter int ALLRED_SEC    = 2,
    parameter int PED_SEC       = 10,
    parameter int MIN_GREEN_SEC = 5,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ped_req,
    input  logic             night_mode,
    output logic [2:0]       main_light,
    output logic [2:0]       side_light,
    output logic             ped_walk,
    output logic [CNT_W-1:0] sec_left,
    output logic [2:0]       state_o,
    output logic             ped_pending
);

    localparam int PW = (CLK_TICKS > 1) ? $clog2(CLK_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_TICKS - 1);

    // Parameter sanity checks, evaluated at elaboration.
    if (CLK_TICKS < 2) begin : g_bad_ticks
        $error("CLK_TICKS must be >= 2");
    end
    if (GREEN_SEC < 1 || YELLOW_SEC < 1 || ALLRED_SEC < 1 || PED_SEC < 1 ||
        MIN_GREEN_SEC < 1 || GREEN_SEC >= (1 << CNT_W) ||
        YELLOW_SEC >= (1 << CNT_W) || ALLRED_SEC >= (1 << CNT_W) ||
        PED_SEC >= (1 << CNT_W) || MIN_GREEN_SEC >= (1 << CNT_W)) begin : g_bad_sec
        $error("phase durations must be in 1..2^CNT_W-1");
    end

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED1    = 3'd2,
        PED_WALK    = 3'd3,
        SIDE_GREEN  = 3'd4,
        SIDE_YELLOW = 3'd5,
        ALL_RED2    = 3'd6,
        NIGHT       = 3'd7
    } state_t;

    state_t           state_q, state_d, nxt_state;
    logic [CNT_W-1:0] sec_left_q, sec_left_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             ped_pending_q, ped_pending_d;
    logic             blink_q, blink_d;
    logic             ped_req_dly_q, ped_req_dly_d;
    logic             tick, expire, ped_rise;

    function automatic logic [CNT_W-1:0] phase_dur(input state_t s);
        case (s)
            MAIN_GREEN, SIDE_GREEN:   phase_dur = CNT_W'(GREEN_SEC);
            MAIN_YELLOW, SIDE_YELLOW: phase_dur = CNT_W'(YELLOW_SEC);
            ALL_RED1, ALL_RED2:       phase_dur = CNT_W'(ALLRED_SEC);
            PED_WALK:                 phase_dur = CNT_W'(PED_SEC);
            default:                  phase_dur = '0;
        endcase
    endfunction

    assign tick     = (presc_q == PRESC_MAX);
    assign ped_rise = ped_req & ~ped_req_dly_q;

    always_comb begin
        state_d       = state_q;
        sec_left_d    = sec_left_q;
        presc_d       = tick ? '0 : presc_q + 1'b1;
        blink_d       = blink_q;
        ped_req_dly_d = ped_req;
        expire        = 1'b0;
        nxt_state     = state_q;

        case (state_q)
            MAIN_GREEN:  nxt_state = MAIN_YELLOW;
            MAIN_YELLOW: nxt_state = ALL_RED1;
            ALL_RED1:    nxt_state = night_mode    ? NIGHT :
                                     ped_pending_q ? PED_WALK : SIDE_GREEN;
            PED_WALK:    nxt_state = SIDE_GREEN;
            SIDE_GREEN:  nxt_state = SIDE_YELLOW;
            SIDE_YELLOW: nxt_state = ALL_RED2;
            ALL_RED2:    nxt_state = night_mode ? NIGHT : MAIN_GREEN;
            default:     nxt_state = ALL_RED2;
        endcase

        if (state_q == NIGHT) begin
            // Countdown parked at 0; leave only on a tick once night ends.
            if (tick) begin
                if (!night_mode) expire = 1'b1;
                else             blink_d = ~blink_q;
            end
        end else if (tick) begin
            if (sec_left_q == CNT_W'(1)) expire = 1'b0 | 1'b1;
            else                         sec_left_d = sec_left_q - 1'b1;
        end

`ifdef TLC_PED_SHORTEN_EN
        // Once cut to the floor the guard fails, so it is applied once.
        // The prescaler keeps running so the current second is not stretched.
        if (state_q == MAIN_GREEN && ped_pending_q &&
            sec_left_q > CNT_W'(MIN_GREEN_SEC))
            sec_left_d = CNT_W'(MIN_GREEN_SEC);
`endif

        if (expire) begin
            state_d    = nxt_state;
            sec_left_d = phase_dur(nxt_state);
            presc_d    = '0;
            blink_d    = 1'b0;
        end

        // A new edge on the same cycle PED_WALK is entered wins over the clear.
        ped_pending_d = ped_pending_q;
        if (expire && nxt_state == PED_WALK) ped_pending_d = 1'b0;
        if (ped_rise)                        ped_pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= MAIN_GREEN;
            sec_left_q    <= CNT_W'(GREEN_SEC);
            presc_q       <= '0;
            ped_pending_q <= 1'b0;
            blink_q       <= 1'b0;
            // Reset high so a button held through reset is not a new press.
            ped_req_dly_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            sec_left_q    <= sec_left_d;
            presc_q       <= presc_d;
            ped_pending_q <= ped_pending_d;
            blink_q       <= blink_d;
            ped_req_dly_q <= ped_req_dly_d;
        end
    end

    always_comb begin
        main_light = 3'b100;
        side_light = 3'b100;
        ped_walk   = 1'b0;
        case (state_q)
            MAIN_GREEN:  main_light = 3'b001;
            MAIN_YELLOW: main_light = 3'b010;
            SIDE_GREEN:  side_light = 3'b001;
            SIDE_YELLOW: side_light = 3'b010;
            PED_WALK:    ped_walk   = 1'b1;
            NIGHT: begin
                main_light = {1'b0, blink_q, 1'b0};
                side_light = {blink_q, 2'b00};
            end
            default: ;
        endcase
    end

    assign sec_left    = sec_left_q;
    assign state_o     = state_q;
    assign ped_pending = ped_pending_q;

endmodule
